// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring integer divider covering DIV, DIVU, REM and REMU.
// Operands are converted to magnitudes on acceptance. One quotient bit is resolved per
// cycle for XLEN cycles, then the sign fix-up is applied on the way into DONE.
// Divide-by-zero and MIN/-1 give the results the RISC-V M extension defines.
// Optional macro DIV_FAST_SPECIAL_EN: a zero divisor or a zero dividend goes straight
// from IDLE to DONE and skips the iteration.
module iter_divider #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_zero,
  output logic            busy
);

  localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              fast;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem_q, quo_q, dvsr_q, a_orig_q;
  logic [1:0]        op_q;
  logic              a_neg_q, b_neg_q;
  logic [XLEN-1:0]   result_q;
  logic              div_zero_q;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     rem_sh, trial;
  logic [XLEN-1:0]   rem_step, quo_step;

  // Two's-complement negate when en is set.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + ONE) : v;
  endfunction

  // Converts the final magnitude quotient/remainder into the architectural result.
  // MIN / -1 needs no special case: |MIN| is MIN, |−1| is 1, and the signs match.
  function automatic logic [XLEN-1:0] fixup(
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem,
    input logic [1:0]      opv,
    input logic            a_neg,
    input logic            b_neg,
    input logic            bzero,
    input logic [XLEN-1:0] a_orig
  );
    logic is_signed;
    is_signed = ~opv[0];
    if (bzero)
      return opv[1] ? a_orig : '1;
    else if (opv[1])
      return neg_if(rem, is_signed & a_neg);
    else
      return neg_if(quo, is_signed & (a_neg ^ b_neg));
  endfunction

  // Magnitudes are taken only for signed ops with the sign bit set.
  always_comb begin
    a_abs = neg_if(a, ~op[0] & a[XLEN-1]);
    b_abs = neg_if(b, ~op[0] & b[XLEN-1]);
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic [XLEN-1:0] fast_result;
  assign fast        = (b == '0) || (a == '0);
  assign fast_result = (b == '0) ? (op[1] ? a : '1) : '0;
`else
  assign fast = 1'b0;
`endif

  // One restoring step: shift {rem, quo} left, subtract the divisor, keep the difference if it is non-negative.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    trial  = rem_sh - {1'b0, dvsr_q};
    if (!trial[XLEN]) begin
      rem_step = trial[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = fast ? DONE : CALC;
        end
      end
      CALC: if (cnt == CNT_ONE) state_nxt = DONE;
      DONE: if (out_ready)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Counter and visible results: these return to zero on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      cnt        <= CNT_INIT;
      div_zero_q <= (b == '0);
`ifdef DIV_FAST_SPECIAL_EN
      result_q   <= fast_result;
`endif
    end else if (state == CALC) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE)
        result_q <= fixup(quo_step, rem_step, op_q, a_neg_q, b_neg_q, div_zero_q, a_orig_q);
    end
  end

  // Iteration datapath: loaded on acceptance, advanced once per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q    <= '0;
      quo_q    <= a_abs;
      dvsr_q   <= b_abs;
      op_q     <= op;
      a_neg_q  <= a[XLEN-1];
      b_neg_q  <= b[XLEN-1];
      a_orig_q <= a;
    end else if (state == CALC) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
    end
  end

  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: a 32-bit and an 8-bit instance are checked
// against an arithmetic reference model, with directed, back-pressure, flush, reset
// and randomized cases.
`timescale 1ns/1ps
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel8;
  logic        in_valid_c, flush_c, out_ready_c;
  logic [1:0]  op_c;
  logic [31:0] a_c, b_c;

  logic        ir32, ov32, dz32, busy32;
  logic [31:0] res32;
  logic        ir8, ov8, dz8, busy8;
  logic [7:0]  res8;

  logic        cur_ir, cur_ov, cur_dz, cur_busy;
  logic [31:0] cur_res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iter_divider #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush_c & ~sel8),
    .in_valid(in_valid_c & ~sel8), .in_ready(ir32),
    .op(op_c), .a(a_c), .b(b_c),
    .out_valid(ov32), .out_ready(out_ready_c & ~sel8),
    .result(res32), .div_zero(dz32), .busy(busy32)
  );

  iter_divider #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush_c & sel8),
    .in_valid(in_valid_c & sel8), .in_ready(ir8),
    .op(op_c), .a(a_c[7:0]), .b(b_c[7:0]),
    .out_valid(ov8), .out_ready(out_ready_c & sel8),
    .result(res8), .div_zero(dz8), .busy(busy8)
  );

  assign cur_ir   = sel8 ? ir8   : ir32;
  assign cur_ov   = sel8 ? ov8   : ov32;
  assign cur_dz   = sel8 ? dz8   : dz32;
  assign cur_busy = sel8 ? busy8 : busy32;
  assign cur_res  = sel8 ? {24'h0, res8} : res32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the RISC-V definitions.
  function automatic logic [31:0] ref_div(input int xl, input logic [1:0] opv,
                                          input logic [31:0] a_i, input logic [31:0] b_i);
    longint m, half, ua, ub, sa, sb, q, r;
    m    = (longint'(1) << xl) - 1;
    half = longint'(1) << (xl - 1);
    ua   = longint'({32'h0, a_i}) & m;
    ub   = longint'({32'h0, b_i}) & m;
    if (ub == 0) begin
      q = m;
      r = ua;
    end else if (opv[0]) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      sa = (ua ^ half) - half;
      sb = (ub ^ half) - half;
      q  = sa / sb;
      r  = sa % sb;
    end
    return 32'(opv[1] ? (r & m) : (q & m));
  endfunction

  function automatic int exp_lat(input int xl, input logic [31:0] a_i, input logic [31:0] b_i);
`ifdef DIV_FAST_SPECIAL_EN
    if (a_i == 32'h0 || b_i == 32'h0) return 1;
`endif
    return xl + 1;
  endfunction

  function automatic logic [31:0] rnd_opnd(input int xl);
    logic [31:0] v, m;
    m = (xl == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'h1 << (xl - 1);
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(1, 9));
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  // Present one request; returns after the accepting edge with inputs scrambled.
  task automatic start_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    in_valid_c = 1'b1;
    op_c = op_i;
    a_c  = a_i;
    b_c  = b_i;
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    op_c = 2'($urandom);
    a_c  = $urandom;
    b_c  = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!cur_ov && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input bit w8, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] exp_res, input string tag);
    int xl, lat;
    logic [31:0] am, bm;
    xl = w8 ? 8 : 32;
    am = w8 ? (a_i & 32'hFF) : a_i;
    bm = w8 ? (b_i & 32'hFF) : b_i;
    sel8 = w8;
    #1;
    check({tag, "_ready"}, 64'(cur_ir), 64'(1));
    start_op(op_i, am, bm);
    wait_valid(lat);
    check({tag, "_res"}, 64'(cur_res), 64'(exp_res));
    check({tag, "_dz"}, 64'(cur_dz), 64'(bm == 32'h0));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(xl, am, bm)));
    out_ready_c = 1'b1;
    @(posedge clk); #1;
    out_ready_c = 1'b0;
    check({tag, "_idle"}, 64'({cur_ov, cur_ir, cur_busy}), 64'(3'b010));
  endtask

  typedef struct packed {
    logic        w8;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int lat, hits;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b0; sel8 = 1'b0;
    in_valid_c = 1'b0; flush_c = 1'b0; out_ready_c = 1'b0;
    op_c = 2'b00; a_c = 32'h0; b_c = 32'h0;

    // Reset values on both widths.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel8 = (s == 1);
      #1;
      check("rst_outputs", 64'({cur_ir, cur_ov, cur_dz, cur_busy}), 64'(4'b1000));
      check("rst_result", 64'(cur_res), 64'(0));
    end
    sel8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    vecs = '{
      '{1'b0, 2'b01, 32'd100,       32'd7,         32'd14},
      '{1'b0, 2'b11, 32'd100,       32'd7,         32'd2},
      '{1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
      '{1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
      '{1'b0, 2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1},
      '{1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
      '{1'b0, 2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF},
      '{1'b0, 2'b00, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF},
      '{1'b0, 2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB},
      '{1'b0, 2'b01, 32'd0,         32'd5,         32'd0},
      '{1'b1, 2'b01, 32'd200,       32'd3,         32'd66},
      '{1'b1, 2'b11, 32'd200,       32'd3,         32'd2},
      '{1'b1, 2'b00, 32'h80,        32'hFF,        32'h80},
      '{1'b1, 2'b11, 32'd5,         32'd0,         32'd5}
    };
    foreach (vecs[i])
      run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("dir%0d", i));

    // Back-pressure: DONE holds its result and refuses new requests.
    sel8 = 1'b0;
    start_op(2'b00, 32'd1000, 32'hFFFF_FFF9);
    wait_valid(lat);
    check("bp_lat", 64'(lat), 64'(33));
    for (int k = 0; k < 5; k++) begin
      in_valid_c = 1'b1;
      a_c = $urandom;
      b_c = $urandom;
      @(posedge clk); #1;
      check("bp_res", 64'(cur_res), 64'(32'hFFFF_FF72));
      check("bp_flags", 64'({cur_ov, cur_ir, cur_dz}), 64'(3'b100));
    end
    in_valid_c = 1'b0;
    out_ready_c = 1'b1;
    @(posedge clk); #1;
    out_ready_c = 1'b0;
    check("bp_release", 64'({cur_ov, cur_ir, cur_busy}), 64'(3'b010));

    // Flush in the middle of CALC discards the op.
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush_c = 1'b1;
    @(posedge clk); #1;
    flush_c = 1'b0;
    check("flush_state", 64'({cur_ov, cur_ir, cur_busy}), 64'(3'b010));
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (cur_ov) hits++;
    end
    check("flush_no_valid", 64'(hits), 64'(0));
    run_op(1'b0, 2'b01, 32'd9, 32'd3, 32'd3, "post_flush");

    // Flush wins over a simultaneous request in IDLE.
    in_valid_c = 1'b1; flush_c = 1'b1;
    a_c = 32'd50; b_c = 32'd5; op_c = 2'b01;
    @(posedge clk); #1;
    in_valid_c = 1'b0; flush_c = 1'b0;
    check("flush_blocks_accept", 64'({cur_busy, cur_ir}), 64'(2'b01));

    // Asynchronous reset in the middle of CALC.
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_flags", 64'({cur_ir, cur_ov, cur_dz, cur_busy}), 64'(4'b1000));
    check("rst_mid_result", 64'(cur_res), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (cur_ov) hits++;
    end
    check("rst_no_valid", 64'(hits), 64'(0));
    run_op(1'b0, 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "post_rst");

    // Randomized traffic on both widths.
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rnd_opnd(32);
      rb  = rnd_opnd(32);
      run_op(1'b0, rop, ra, rb, ref_div(32, rop, ra, rb), "rnd32");
    end
    for (int i = 0; i < 100; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rnd_opnd(8);
      rb  = rnd_opnd(8);
      run_op(1'b1, rop, ra, rb, ref_div(8, rop, ra, rb), "rnd8");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
